// File: rtl/mod_cnt_pkg.sv
// Shared types and arithmetic helpers for the modulo-N counter family.
// Also reused by the cascade chain block.
package mod_cnt_pkg;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   function automatic int unsigned clamp_load(input int unsigned val, input int unsigned modulus);
      return (val < modulus) ? val : modulus - 32'd1;
   endfunction

   // Arithmetic is 32 bits wide so the top count of a 2**WIDTH modulus never overflows.
   function automatic int unsigned next_count(input int unsigned q, input logic up_dn,
                                              input int unsigned modulus);
      if (up_dn == DIR_DN) begin
         return (q == 32'd0) ? modulus - 32'd1 : q - 32'd1;
      end
      return (q == modulus - 32'd1) ? 32'd0 : q + 32'd1;
   endfunction

endpackage

// File: rtl/mod_n_next_val.sv
// Combinational next-count, terminal-count and wrap generation for mod_n_counter.
module mod_n_next_val
   import mod_cnt_pkg::*;
#(
   parameter int MODULUS = 10,
   parameter int WIDTH   = 4
) (
   input  logic [WIDTH-1:0] q,
   input  logic             up_dn,
   input  logic             en,
   output logic [WIDTH-1:0] next_q,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH:0] MAX_V = (WIDTH+1)'(MODULUS - 1);

   logic [WIDTH:0] qExt;

   // One extra bit on the compare so MODULUS == 2**WIDTH still has a representable top value.
   always_comb begin
      qExt   = {1'b0, q};
      tc     = (up_dn == DIR_UP) ? (qExt == MAX_V) : (qExt == '0);
      wrap   = en & tc;
      next_q = q;
      if (en) begin
         next_q = WIDTH'(next_count(32'(qExt), up_dn, 32'(MODULUS)));
      end
   end

endmodule

// File: rtl/mod_n_counter.sv
// Parametrised modulo-N up/down counter with clear, load and cascade carry.
// Optional sticky overflow flag: define MOD_N_COUNTER_OVF_STICKY_EN.
module mod_n_counter
   import mod_cnt_pkg::*;
#(
   parameter int MODULUS = 10,
   parameter int WIDTH   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             co
`ifdef MOD_N_COUNTER_OVF_STICKY_EN
   ,
   output logic             ovf
`endif
);

   if (MODULUS < 2 || MODULUS > 65536) begin : g_bad_modulus
      $error("mod_n_counter: MODULUS %0d outside 2..65536", MODULUS);
   end
   if ((64'd1 << WIDTH) < 64'(MODULUS)) begin : g_bad_width
      $error("mod_n_counter: WIDTH %0d too narrow for MODULUS %0d", WIDTH, MODULUS);
   end

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] nextVal;
   logic             tcInt;
   logic             wrap;

   mod_n_next_val #(
      .MODULUS (MODULUS),
      .WIDTH   (WIDTH)
   ) u_next_val (
      .q      (count_q),
      .up_dn  (up_dn),
      .en     (en),
      .next_q (nextVal),
      .tc     (tcInt),
      .wrap   (wrap)
   );

   assign q  = count_q;
   assign tc = tcInt;
   assign co = wrap;

   // Priority: clear, then load (clamped into range), then count/hold.
   always_comb begin
      count_d = nextVal;
      if (clr) begin
         count_d = '0;
      end else if (load) begin
         count_d = WIDTH'(clamp_load(32'(load_val), 32'(MODULUS)));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

`ifdef MOD_N_COUNTER_OVF_STICKY_EN
   logic ovf_q;
   logic ovf_d;

   // Sticky: only clear or reset drops it, and clear beats a simultaneous wrap.
   always_comb begin
      ovf_d = ovf_q;
      if (clr) begin
         ovf_d = 1'b0;
      end else if (!load && wrap) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_mod_n_counter.sv
// Scoreboard bench for mod_n_counter: decade, power-of-two, mod-60 and a two-digit cascade.
module tb_mod_n_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, rstC;
   logic       en, up_dn, clr, load;
   logic [3:0] load_val, q;
   logic       tc, co;

   logic       en16, load16, tc16, co16;
   logic [3:0] lv16, q16;
   logic       en60, load60, tc60, co60;
   logic [5:0] lv60, q60;
   logic [3:0] qLo, qHi;
   logic       tcLo, coLo, tcHi, coHi;
`ifdef MOD_N_COUNTER_OVF_STICKY_EN
   logic       ovf, ovf16, ovf60, ovfLo, ovfHi;
`endif

   int testsRun    = 0;
   int testsFailed = 0;
   int expQ[$];
   int mq;
   int movf;

   mod_n_counter #(.MODULUS(10), .WIDTH(4)) dut (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
      .load_val(load_val), .q(q), .tc(tc), .co(co)
`ifdef MOD_N_COUNTER_OVF_STICKY_EN
      , .ovf(ovf)
`endif
   );

   mod_n_counter #(.MODULUS(16), .WIDTH(4)) dut16 (
      .clk(clk), .rst(rst), .en(en16), .up_dn(1'b1), .clr(1'b0), .load(load16),
      .load_val(lv16), .q(q16), .tc(tc16), .co(co16)
`ifdef MOD_N_COUNTER_OVF_STICKY_EN
      , .ovf(ovf16)
`endif
   );

   mod_n_counter #(.MODULUS(60), .WIDTH(6)) dut60 (
      .clk(clk), .rst(rst), .en(en60), .up_dn(1'b1), .clr(1'b0), .load(load60),
      .load_val(lv60), .q(q60), .tc(tc60), .co(co60)
`ifdef MOD_N_COUNTER_OVF_STICKY_EN
      , .ovf(ovf60)
`endif
   );

   mod_n_counter #(.MODULUS(10), .WIDTH(4)) dutLo (
      .clk(clk), .rst(rstC), .en(1'b1), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
      .load_val(4'd0), .q(qLo), .tc(tcLo), .co(coLo)
`ifdef MOD_N_COUNTER_OVF_STICKY_EN
      , .ovf(ovfLo)
`endif
   );

   mod_n_counter #(.MODULUS(10), .WIDTH(4)) dutHi (
      .clk(clk), .rst(rstC), .en(coLo), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
      .load_val(4'd0), .q(qHi), .tc(tcHi), .co(coHi)
`ifdef MOD_N_COUNTER_OVF_STICKY_EN
      , .ovf(ovfHi)
`endif
   );

   // Drives the decade DUT and pushes the model's next count (and sticky flag) to the scoreboard.
   task automatic applyStimulus(input logic e, input logic u, input logic c, input logic l,
                                input logic [3:0] lv);
      logic tcPre;
      en = e; up_dn = u; clr = c; load = l; load_val = lv;
      tcPre = u ? (mq == 9) : (mq == 0);
      if (c) movf = 0;
      else if (!l && e && tcPre) movf = 1;
      if (c) mq = 0;
      else if (l) mq = (int'(lv) > 9) ? 9 : int'(lv);
      else if (e) mq = u ? (mq + 1) % 10 : (mq + 9) % 10;
      expQ.push_back(mq);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      int e;
      #1;
      testsRun++; if (int'(q) !== 0) begin testsFailed++; $display("[TB] FAIL reset_q: got %0d expected 0", q); end
      testsRun++; if (tc !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_tc_down: got %b expected 1", tc); end
      testsRun++; if (co !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_co: got %b expected 0", co); end
`ifdef MOD_N_COUNTER_OVF_STICKY_EN
      testsRun++; if (ovf !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ovf: got %b expected 0", ovf); end
`endif
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
         step();
         e = expQ.pop_front();
         testsRun++; if (int'(q) !== e) begin testsFailed++; $display("[TB] FAIL prereset_q: got %0d expected %0d", q, e); end
      end
      #2;
      rst = 1'b0;
      en  = 1'b0;
      #1;
      mq = 0; movf = 0;
      testsRun++; if (int'(q) !== 0) begin testsFailed++; $display("[TB] FAIL async_reset_q: got %0d expected 0", q); end
      testsRun++; if (tc !== 1'b0) begin testsFailed++; $display("[TB] FAIL async_reset_tc_up: got %b expected 0", tc); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_up_count();
      int e, coSeen;
      logic tcExp;
      coSeen = 0;
      for (int i = 0; i < 12; i++) begin
         tcExp = (mq == 9);
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
         #1;
         testsRun++; if (tc !== tcExp) begin testsFailed++; $display("[TB] FAIL up_tc: got %b expected %b", tc, tcExp); end
         testsRun++; if (co !== tcExp) begin testsFailed++; $display("[TB] FAIL up_co: got %b expected %b", co, tcExp); end
         if (co === 1'b1) coSeen++;
         step();
         e = expQ.pop_front();
         testsRun++; if (int'(q) !== e) begin testsFailed++; $display("[TB] FAIL up_q: got %0d expected %0d", q, e); end
      end
      testsRun++; if (coSeen !== 1) begin testsFailed++; $display("[TB] FAIL up_co_count: got %0d expected 1", coSeen); end
   endtask

   task automatic test_down_wrap();
      int e;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      step();
      e = expQ.pop_front();
      testsRun++; if (int'(q) !== e) begin testsFailed++; $display("[TB] FAIL down_clr_q: got %0d expected %0d", q, e); end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      #1;
      testsRun++; if (tc !== 1'b1) begin testsFailed++; $display("[TB] FAIL down_tc_at0: got %b expected 1", tc); end
      testsRun++; if (co !== 1'b1) begin testsFailed++; $display("[TB] FAIL down_co_at0: got %b expected 1", co); end
      step();
      e = expQ.pop_front();
      testsRun++; if (int'(q) !== e) begin testsFailed++; $display("[TB] FAIL down_wrap_q: got %0d expected %0d", q, e); end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      #1;
      testsRun++; if (tc !== 1'b0) begin testsFailed++; $display("[TB] FAIL down_tc_at9: got %b expected 0", tc); end
      step();
      e = expQ.pop_front();
      testsRun++; if (int'(q) !== e) begin testsFailed++; $display("[TB] FAIL down_q: got %0d expected %0d", q, e); end
   endtask

   task automatic test_load_clamp();
      int e;
      logic [3:0] vals [4] = '{4'd7, 4'd13, 4'd3, 4'd15};
      logic       ens  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(ens[i], 1'b1, 1'b0, 1'b1, vals[i]);
         step();
         e = expQ.pop_front();
         testsRun++; if (int'(q) !== e) begin testsFailed++; $display("[TB] FAIL load_q(val=%0d): got %0d expected %0d", vals[i], q, e); end
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      #1;
      testsRun++; if (tc !== 1'b1) begin testsFailed++; $display("[TB] FAIL hold_tc: got %b expected 1", tc); end
      testsRun++; if (co !== 1'b0) begin testsFailed++; $display("[TB] FAIL hold_co_en0: got %b expected 0", co); end
      step();
      e = expQ.pop_front();
      testsRun++; if (int'(q) !== e) begin testsFailed++; $display("[TB] FAIL hold_q: got %0d expected %0d", q, e); end
   endtask

   task automatic test_priority();
      int e;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
      step();
      e = expQ.pop_front();
      testsRun++; if (int'(q) !== e) begin testsFailed++; $display("[TB] FAIL prio_clr_q: got %0d expected %0d", q, e); end
   endtask

   task automatic test_direction_change();
      int e;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd9);
      step();
      e = expQ.pop_front();
      testsRun++; if (int'(q) !== e) begin testsFailed++; $display("[TB] FAIL dir_load_q: got %0d expected %0d", q, e); end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      #1;
      testsRun++; if (tc !== 1'b0) begin testsFailed++; $display("[TB] FAIL dir_tc_flip: got %b expected 0", tc); end
      step();
      e = expQ.pop_front();
      testsRun++; if (int'(q) !== e) begin testsFailed++; $display("[TB] FAIL dir_down_q: got %0d expected %0d", q, e); end
   endtask

   task automatic test_pow2();
      int e;
      load16 = 1'b1; lv16 = 4'd15; expQ.push_back(15);
      step();
      load16 = 1'b0;
      e = expQ.pop_front();
      testsRun++; if (int'(q16) !== e) begin testsFailed++; $display("[TB] FAIL m16_load_q: got %0d expected %0d", q16, e); end
      en16 = 1'b1; expQ.push_back(0);
      #1;
      testsRun++; if (co16 !== 1'b1) begin testsFailed++; $display("[TB] FAIL m16_co_at15: got %b expected 1", co16); end
      step();
      en16 = 1'b0;
      e = expQ.pop_front();
      testsRun++; if (int'(q16) !== e) begin testsFailed++; $display("[TB] FAIL m16_wrap_q: got %0d expected %0d", q16, e); end
      load60 = 1'b1; lv60 = 6'd63; expQ.push_back(59);
      step();
      load60 = 1'b0;
      e = expQ.pop_front();
      testsRun++; if (int'(q60) !== e) begin testsFailed++; $display("[TB] FAIL m60_clamp_q: got %0d expected %0d", q60, e); end
      en60 = 1'b1; expQ.push_back(0);
      #1;
      testsRun++; if (co60 !== 1'b1) begin testsFailed++; $display("[TB] FAIL m60_co_at59: got %b expected 1", co60); end
      step();
      en60 = 1'b0;
      e = expQ.pop_front();
      testsRun++; if (int'(q60) !== e) begin testsFailed++; $display("[TB] FAIL m60_wrap_q: got %0d expected %0d", q60, e); end
   endtask

   task automatic test_cascade();
      int e, total, coCount;
      total = 0; coCount = 0;
      rstC = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (coHi === 1'b1) coCount++;
         total = (total + 1) % 100;
         expQ.push_back(total);
         step();
         e = expQ.pop_front();
         testsRun++;
         if (int'(qLo) !== e % 10 || int'(qHi) !== e / 10) begin
            testsFailed++;
            $display("[TB] FAIL cascade_pair: got %0d%0d expected %0d", qHi, qLo, e);
         end
      end
      testsRun++; if (coCount !== 1) begin testsFailed++; $display("[TB] FAIL cascade_co_count: got %0d expected 1", coCount); end
   endtask

`ifdef MOD_N_COUNTER_OVF_STICKY_EN
   task automatic test_ovf();
      int e;
      logic vE [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic vC [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic vL [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [3:0] vV [6] = '{4'd0, 4'd9, 4'd0, 4'd4, 4'd0, 4'd0};
      for (int i = 0; i < 6; i++) begin
         if (i == 5) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd9);
            step();
            void'(expQ.pop_front());
         end
         applyStimulus(vE[i], 1'b1, vC[i], vL[i], vV[i]);
         step();
         e = expQ.pop_front();
         testsRun++; if (int'(q) !== e) begin testsFailed++; $display("[TB] FAIL ovf_step_q(%0d): got %0d expected %0d", i, q, e); end
         testsRun++; if (int'(ovf) !== movf) begin testsFailed++; $display("[TB] FAIL ovf_flag(%0d): got %b expected %0d", i, ovf, movf); end
      end
   endtask
`endif

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b0; rstC = 1'b0;
      en = 1'b0; up_dn = 1'b0; clr = 1'b0; load = 1'b0; load_val = 4'd0;
      en16 = 1'b0; load16 = 1'b0; lv16 = 4'd0;
      en60 = 1'b0; load60 = 1'b0; lv60 = 6'd0;
      mq = 0; movf = 0;
      test_reset();
      test_up_count();
      test_down_wrap();
      test_load_clamp();
      test_priority();
      test_direction_change();
      test_pow2();
      test_cascade();
`ifdef MOD_N_COUNTER_OVF_STICKY_EN
      test_ovf();
`endif
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/mod_n_counter.md
Name: mod_n_counter

Overview:
- Parametrised modulo-N up/down counter; successor to the fixed decade counter.
- Adds count enable, direction, synchronous clear, parallel load, and terminal-count/carry outputs, so instances cascade into multi-digit BCD or arbitrary-radix chains.
- Sits in the primary-circuits library as the standard counter primitive for timers, dividers and display scanners.

Parameters:
- MODULUS, 10, count range 0..MODULUS-1; legal range 2..65536.
- WIDTH, 4, width of q and load_val; elaboration error if 2**WIDTH < MODULUS.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; one clock; reset is asynchronous and active-low.
- en  input  1  count enable.
- up_dn  input  1  1 = count up, 0 = count down.
- clr  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value for load.
- q  output  WIDTH  registered count.
- tc  output  1  terminal count, combinational from q and up_dn: up and q==MODULUS-1, or down and q==0.
- co  output  1  cascade carry/borrow = en & tc.

Behaviour:
- Reset:
  - rst low forces q=0 immediately, without waiting for clk.
  - tc and co follow q.
  - Release is synchronous-safe; the first count happens at the first clk edge with rst high.
- Priority per rising edge: clr > load > en > hold.
- clr=1: q <= 0, regardless of en or load.
- load=1 (clr=0): q <= load_val if load_val < MODULUS, else q <= MODULUS-1 (clamp). en is ignored that cycle.
- en=1, up_dn=1: q <= (q==MODULUS-1) ? 0 : q+1.
- en=1, up_dn=0: q <= (q==0) ? MODULUS-1 : q-1.
- en=0: q holds.
- Latency: one cycle from input to q. tc and co have zero-cycle latency from q, up_dn and en.
- Wrap rule: co is high exactly in the cycle before a wrap, so the next stage's en is driven directly by co.
- Direction change mid-count: takes effect on the next edge. tc re-evaluates immediately.
- Width arithmetic: compare and increment in WIDTH+1 bits so MODULUS == 2**WIDTH wraps correctly with no overflow.
- q is never outside 0..MODULUS-1, including after load.

Optional Feature:
- Macro: MOD_N_COUNTER_OVF_STICKY_EN.
- Defined: adds output port ovf (1 bit).
  - Reset value 0.
  - Set on any edge where a wrap occurs (co=1 with no clr/load).
  - Cleared only by clr or reset; load does not clear it.
  - Set and clear in the same cycle resolve to clear.
- Undefined: ovf port and its register are absent; all other behaviour is identical.

Decomposition:
- Package mod_cnt_pkg holds:
  - localparam DIR_UP = 1'b1 and DIR_DN = 1'b0;
  - function clamp_load(val, modulus);
  - function next_count(q, up_dn, modulus), shared with the future cascade chain block.
- One combinational sub-module is natural: mod_n_next_val (q, up_dn, en → next q, wrap flag). The top keeps the register, priority mux and optional ovf.

Test Plan:
- Reset and up-count (MODULUS=10):
  - rst low mid-cycle → q=0 asynchronously.
  - Release; en=1, up_dn=1 for 12 clocks → q runs 1..9, 0, 1, 2.
  - tc=co=1 only while q=9.
- Down-count wrap (MODULUS=10): q=0, en=1, up_dn=0 → q=9 next edge; tc=1 at q=0.
- Load and clamp (MODULUS=10, WIDTH=4):
  - load_val=7 → q=7.
  - load_val=13 → q=9.
  - load=1 with en=1 → loaded value wins; no increment.
- Priority: clr=1, load=1, en=1 with load_val=5 → q=0.
- Power-of-two modulus (MODULUS=16, WIDTH=4): q=15, up → q=0, co=1 in the prior cycle. Second instance, MODULUS=60, WIDTH=6: q=59 → 0.
- Cascade and option:
  - Two instances (MODULUS=10), second en = first co; 100 clocks → pair reads 0,0 with exactly one co from the second stage.
  - With MOD_N_COUNTER_OVF_STICKY_EN: ovf=1 after the first wrap, stays 1 through a load, and is cleared by clr.
